// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_ctrl
// Brief    : HUB75 row/bit-plane scan sequencer; shifts (row, plane) while the
//            previous one is lit for its BCM on-time. Optional frame handshake
//            is enabled by defining HUB75_SCAN_FRAME_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl #(
    parameter int N_BANKS       = 2,
    parameter int N_ROWS        = 32,
    parameter int N_COLS        = 64,
    parameter int N_CHANS       = 3,
    parameter int N_PLANES      = 8,
    parameter int BCM_LSB_LEN   = 16,
    localparam int LOG_N_ROWS   = $clog2(N_ROWS),
    localparam int LOG_N_COLS   = $clog2(N_COLS),
    localparam int LOG_N_PLANES = $clog2(N_PLANES),
    localparam int DATA_W       = N_BANKS * N_CHANS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ctrl_run,
    output logic [LOG_N_ROWS-1:0]   rd_row,
    output logic [LOG_N_COLS-1:0]   rd_col,
    output logic [LOG_N_PLANES-1:0] rd_plane,
    input  logic [DATA_W-1:0]       rd_data,
    output logic [LOG_N_ROWS-1:0]   phy_addr,
    output logic [DATA_W-1:0]       phy_data,
    output logic                    phy_clk,
    output logic                    phy_le,
    output logic                    phy_blank
`ifdef HUB75_SCAN_FRAME_SYNC_EN
    ,
    input  logic                    frame_ready,
    output logic                    frame_swap
`endif
);

    localparam int ON_W = $clog2(BCM_LSB_LEN << (N_PLANES - 1)) + 1;

    localparam logic [ON_W-1:0]         c_on_lsb     = ON_W'(BCM_LSB_LEN);
    localparam logic [ON_W-1:0]         c_on_one     = ON_W'(1);
    localparam logic [LOG_N_COLS-1:0]   c_last_col   = LOG_N_COLS'(N_COLS - 1);
    localparam logic [LOG_N_ROWS-1:0]   c_last_row   = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_PLANES-1:0] c_last_plane = LOG_N_PLANES'(N_PLANES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREFETCH = 3'd1,
        S_SHIFT    = 3'd2,
        S_WAIT     = 3'd3,
        S_BLANK    = 3'd4,
        S_LATCH    = 3'd5,
        S_SYNC     = 3'd6
    } state_t;

    state_t                  r_state;
    logic [LOG_N_COLS-1:0]   r_col;
    logic                    r_phase;
    logic [ON_W-1:0]         r_on_cnt;
    logic [LOG_N_PLANES-1:0] r_lat_plane;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_on_cnt    <= '0;
            r_lat_plane <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            rd_plane    <= '0;
            phy_addr    <= '0;
            phy_data    <= '0;
            phy_clk     <= 1'b0;
            phy_le      <= 1'b0;
            phy_blank   <= 1'b1;
`ifdef HUB75_SCAN_FRAME_SYNC_EN
            frame_swap  <= 1'b0;
`endif
        end else begin
`ifdef HUB75_SCAN_FRAME_SYNC_EN
            frame_swap <= 1'b0;
`endif
            // On-time runs beside the FSM so it overlaps the next shift.
            if (phy_le) begin
                phy_le    <= 1'b0;
                phy_blank <= 1'b0;
                r_on_cnt  <= c_on_lsb << r_lat_plane;
            end else if (r_on_cnt != '0) begin
                r_on_cnt <= r_on_cnt - 1'b1;
                if (r_on_cnt == c_on_one) begin
                    phy_blank <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (ctrl_run) begin
                        rd_row   <= '0;
                        rd_plane <= '0;
                        rd_col   <= '0;
`ifdef HUB75_SCAN_FRAME_SYNC_EN
                        r_state  <= S_SYNC;
`else
                        r_state  <= S_PREFETCH;
`endif
                    end
                end
`ifdef HUB75_SCAN_FRAME_SYNC_EN
                S_SYNC: begin
                    if (frame_ready) begin
                        frame_swap <= 1'b1;
                        r_state    <= S_PREFETCH;
                    end
                end
`endif
                S_PREFETCH: begin
                    r_col   <= '0;
                    r_phase <= 1'b0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!r_phase) begin
                        phy_data <= rd_data;
                        phy_clk  <= 1'b0;
                        rd_col   <= (r_col == c_last_col) ? '0 : r_col + 1'b1;
                        r_phase  <= 1'b1;
                    end else begin
                        phy_clk <= 1'b1;
                        r_phase <= 1'b0;
                        if (r_col == c_last_col) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    phy_clk <= 1'b0;
                    if (r_on_cnt == '0) begin
                        r_state <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    phy_blank   <= 1'b1;
                    phy_addr    <= rd_row;
                    r_lat_plane <= rd_plane;
                    r_state     <= S_LATCH;
                end
                S_LATCH: begin
                    phy_le <= 1'b1;
                    if (rd_plane == c_last_plane) begin
                        rd_plane <= '0;
                        rd_row   <= (rd_row == c_last_row) ? '0 : rd_row + 1'b1;
                    end else begin
                        rd_plane <= rd_plane + 1'b1;
                    end
                    if (!ctrl_run) begin
                        r_state <= S_IDLE;
`ifdef HUB75_SCAN_FRAME_SYNC_EN
                    end else if (rd_plane == c_last_plane && rd_row == c_last_row) begin
                        r_state <= S_SYNC;
`endif
                    end else begin
                        r_state <= S_PREFETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// Bench for hub75_scan_ctrl: random frame contents and run/stop/reset timing,
// scored by an event-level model of shifted rows, latches and BCM windows.
module tb_hub75_scan_ctrl;

    localparam int N_BANKS     = 2;
    localparam int N_ROWS      = 4;
    localparam int N_COLS      = 4;
    localparam int N_CHANS     = 3;
    localparam int N_PLANES    = 2;
    localparam int BCM_LSB_LEN = 8;
    localparam int DATA_W      = N_BANKS * N_CHANS;
    localparam int RW          = $clog2(N_ROWS);
    localparam int CW          = $clog2(N_COLS);
    localparam int PW          = $clog2(N_PLANES);

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ctrl_run = 1'b0;

    logic [RW-1:0]     rd_row, phy_addr;
    logic [CW-1:0]     rd_col;
    logic [PW-1:0]     rd_plane;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] phy_data;
    logic              phy_clk, phy_le, phy_blank;

    logic [RW-1:0]     rd_row2, phy_addr2;
    logic [CW-1:0]     rd_col2;
    logic [PW-1:0]     rd_plane2;
    logic [DATA_W-1:0] rd_data2 = '0;
    logic [DATA_W-1:0] phy_data2;
    logic              phy_clk2, phy_le2, phy_blank2;

`ifdef HUB75_SCAN_FRAME_SYNC_EN
    logic frame_ready  = 1'b1;
    logic frame_ready2 = 1'b1;
    logic frame_swap, frame_swap2;
`endif

    hub75_scan_ctrl #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .N_CHANS(N_CHANS),
        .N_PLANES(N_PLANES), .BCM_LSB_LEN(BCM_LSB_LEN)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_run(ctrl_run),
        .rd_row(rd_row), .rd_col(rd_col), .rd_plane(rd_plane), .rd_data(rd_data),
        .phy_addr(phy_addr), .phy_data(phy_data), .phy_clk(phy_clk),
        .phy_le(phy_le), .phy_blank(phy_blank)
`ifdef HUB75_SCAN_FRAME_SYNC_EN
        , .frame_ready(frame_ready), .frame_swap(frame_swap)
`endif
    );

    // Second instance with a one-cycle LSB on-time, much shorter than a shift.
    hub75_scan_ctrl #(
        .N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .N_CHANS(N_CHANS),
        .N_PLANES(N_PLANES), .BCM_LSB_LEN(1)
    ) dut_short (
        .clk(clk), .rst(rst), .ctrl_run(ctrl_run),
        .rd_row(rd_row2), .rd_col(rd_col2), .rd_plane(rd_plane2), .rd_data(rd_data2),
        .phy_addr(phy_addr2), .phy_data(phy_data2), .phy_clk(phy_clk2),
        .phy_le(phy_le2), .phy_blank(phy_blank2)
`ifdef HUB75_SCAN_FRAME_SYNC_EN
        , .frame_ready(frame_ready2), .frame_swap(frame_swap2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Frame buffer with one cycle of read latency.
    logic [DATA_W-1:0] mem [N_ROWS][N_PLANES][N_COLS];
    always @(posedge clk) rd_data <= mem[rd_row][rd_plane][rd_col];

    logic [DATA_W-1:0] sh_q [$];
    int exp_row = 0, exp_plane = 0, lat_plane = 0, low_cnt = 0;
    int rise_cnt = 0, le_cnt = 0, swap_cnt = 0;
    logic p_clk = 1'b0, p_blank = 1'b1, p_le = 1'b0, p_run = 1'b0, p_swap = 1'b0;
    logic [DATA_W-1:0] p_data = '0;
    logic [RW-1:0]     p_addr = '0;

    always @(negedge clk) begin
        if (rst) begin
            sh_q.delete();
            exp_row = 0; exp_plane = 0; low_cnt = 0;
            p_clk = 1'b0; p_blank = 1'b1; p_le = 1'b0; p_swap = 1'b0;
            p_data = '0; p_addr = '0;
        end else begin
            if (ctrl_run && !p_run) begin
                exp_row = 0; exp_plane = 0;
            end
            if (phy_data != p_data) check("data_moves_clk_low", int'(phy_clk), 0);
            if (phy_clk) begin
                check("clk_high_one_cycle", int'(p_clk), 0);
                if (!p_clk) begin
                    rise_cnt++;
                    sh_q.push_back(phy_data);
                end
            end
            if (phy_le) begin
                check("le_one_cycle", int'(p_le), 0);
                if (!p_le) begin
                    check("le_addr", int'(phy_addr), exp_row);
                    check("le_while_blank", int'(phy_blank), 1);
                    check("cols_shifted", sh_q.size(), N_COLS);
                    for (int c = 0; c < N_COLS && c < sh_q.size(); c++)
                        check("pixel", int'(sh_q[c]), int'(mem[exp_row][exp_plane][c]));
                    sh_q.delete();
                    lat_plane = exp_plane;
                    le_cnt++;
                    exp_plane++;
                    if (exp_plane == N_PLANES) begin
                        exp_plane = 0;
                        exp_row   = (exp_row + 1) % N_ROWS;
                    end
                end
            end
            if (!phy_blank) begin
                low_cnt++;
                check("addr_stable_lit", int'(phy_addr), int'(p_addr));
                if (p_blank) check("unblank_after_le", int'(p_le), 1);
            end else if (!p_blank) begin
                check("on_time", low_cnt, BCM_LSB_LEN << lat_plane);
                low_cnt = 0;
            end
`ifdef HUB75_SCAN_FRAME_SYNC_EN
            if (frame_swap) begin
                check("swap_one_cycle", int'(p_swap), 0);
                if (!p_swap) swap_cnt++;
            end
            p_swap = frame_swap;
`endif
            p_clk = phy_clk; p_blank = phy_blank; p_le = phy_le;
            p_data = phy_data; p_addr = phy_addr;
        end
        p_run = ctrl_run;
    end

    int exp_plane2 = 0, lat2 = 0, low2 = 0;
    logic q_blank = 1'b1, q_le = 1'b0, q_run = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_plane2 = 0; low2 = 0; q_blank = 1'b1; q_le = 1'b0;
        end else begin
            if (ctrl_run && !q_run) exp_plane2 = 0;
            if (phy_le2 && !q_le) begin
                lat2       = exp_plane2;
                exp_plane2 = (exp_plane2 + 1) % N_PLANES;
            end
            if (!phy_blank2) begin
                low2++;
                if (q_blank) check("short_unblank_after_le", int'(q_le), 1);
            end else if (!q_blank) begin
                check("short_on_time", low2, 1 << lat2);
                low2 = 0;
            end
            q_blank = phy_blank2; q_le = phy_le2;
        end
        q_run = ctrl_run;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mem(input bit random_fill);
        for (int r = 0; r < N_ROWS; r++)
            for (int p = 0; p < N_PLANES; p++)
                for (int c = 0; c < N_COLS; c++)
                    mem[r][p][c] = random_fill ? DATA_W'($urandom) : DATA_W'(c);
    endtask

    task automatic wait_le(input int n, input int budget);
        int s, k;
        s = le_cnt;
        k = 0;
        while (le_cnt - s < n && k < budget) begin
            tick();
            k++;
        end
        check("latch_progress", le_cnt - s, n);
    endtask

    task automatic stop_run();
        int l0, r1, k;
        repeat ($urandom_range(0, 30)) tick();
        k = 0;
        while (phy_le && k < 10) begin
            tick();
            k++;
        end
        ctrl_run = 1'b0;
        l0 = le_cnt;
        repeat (250) tick();
        check("stop_after_one_latch", le_cnt - l0, 1);
        check("stop_blank", int'(phy_blank), 1);
        r1 = rise_cnt;
        repeat (20) tick();
        check("stop_no_clk", rise_cnt - r1, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_blank"}, int'(phy_blank), 1);
        check({tag, "_addr"}, int'(phy_addr), 0);
        check({tag, "_data"}, int'(phy_data), 0);
        check({tag, "_clk"}, int'(phy_clk), 0);
        check({tag, "_le"}, int'(phy_le), 0);
        check({tag, "_rd_row"}, int'(rd_row), 0);
        check({tag, "_rd_col"}, int'(rd_col), 0);
        check({tag, "_rd_plane"}, int'(rd_plane), 0);
        check({tag, "_short_blank"}, int'(phy_blank2), 1);
`ifdef HUB75_SCAN_FRAME_SYNC_EN
        check({tag, "_swap"}, int'(frame_swap), 0);
`endif
    endtask

    initial begin
        int r0, l0, k;
`ifdef HUB75_SCAN_FRAME_SYNC_EN
        int s0;
`endif
        fill_mem(1'b0);
        rst = 1'b1;
        ctrl_run = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (10) tick();
        check("idle_no_clk", rise_cnt, 0);
        check("idle_blank", int'(phy_blank), 1);

        // Column-index frame, then a full frame plus the wrap back to row 0.
        ctrl_run = 1'b1;
        wait_le(9, 2000);
        stop_run();

        for (int it = 0; it < 3; it++) begin
            fill_mem(1'b1);
            ctrl_run = 1'b1;
            wait_le($urandom_range(3, 12), 3000);
            stop_run();
        end

        // Reset while a row is being shifted.
        ctrl_run = 1'b1;
        r0 = rise_cnt;
        k = 0;
        while (rise_cnt == r0 && k < 500) begin
            tick();
            k++;
        end
        check("shift_started", int'(rise_cnt > r0), 1);
        repeat ($urandom_range(0, 3)) tick();
        rst = 1'b1;
        ctrl_run = 1'b0;
        l0 = le_cnt;
        tick();
        check_reset_values("mid_rst");
        tick();
        rst = 1'b0;
        r0 = rise_cnt;
        repeat (20) tick();
        check("rst_no_clk", rise_cnt - r0, 0);
        check("rst_no_latch", le_cnt - l0, 0);

`ifdef HUB75_SCAN_FRAME_SYNC_EN
        frame_ready = 1'b0;
        ctrl_run = 1'b1;
        r0 = rise_cnt;
        s0 = swap_cnt;
        repeat (40) tick();
        check("sync_stall_clk", rise_cnt - r0, 0);
        check("sync_stall_swap", swap_cnt - s0, 0);
        frame_ready = 1'b1;
        repeat (12) tick();
        check("sync_swap", swap_cnt - s0, 1);
        check("sync_resume", int'(rise_cnt > r0), 1);
        wait_le(8, 3000);
        repeat (6) tick();
        check("sync_wrap_swap", swap_cnt - s0, 2);
        stop_run();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Scan sequencer that drives the `hub75_phy` PHY interface signals for a multiplexed HUB75 panel. It walks rows and bit-planes. For each (row, plane) it reads one column bit-vector per column from the frame/line buffer and shifts it out with `phy_clk`. It then blanks, updates the row address, latches, and un-blanks for a binary-weighted on-time. Shifting of the next (row, plane) overlaps the on-time of the current one.

## Interface
- `N_BANKS`, 2: panel banks driven in parallel.
- `N_ROWS`, 32: rows per bank; `LOG_N_ROWS = $clog2(N_ROWS)`.
- `N_COLS`, 64: columns per row; `LOG_N_COLS = $clog2(N_COLS)`.
- `N_CHANS`, 3: colour channels per bank.
- `N_PLANES`, 8: BCM bit-planes; `LOG_N_PLANES = $clog2(N_PLANES)`.
- `BCM_LSB_LEN`, 16: on-time in `clk` cycles of plane 0; plane p gets `BCM_LSB_LEN << p`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; synchronous, active-high.
- `ctrl_run`  in  1  enable scanning; sampled only at the points stated below.
- `rd_row`  out  LOG_N_ROWS  buffer read row.
- `rd_col`  out  LOG_N_COLS  buffer read column.
- `rd_plane`  out  LOG_N_PLANES  buffer read bit-plane.
- `rd_data`  in  N_BANKS*N_CHANS  buffer data; valid exactly 1 cycle after address.
- `phy_addr`  out  LOG_N_ROWS  row address to PHY.
- `phy_data`  out  N_BANKS*N_CHANS  pixel bits to PHY.
- `phy_clk`  out  1  shift clock to PHY.
- `phy_le`  out  1  latch enable to PHY.
- `phy_blank`  out  1  blank (high = LEDs off) to PHY.
- `frame_ready`  in  1  only with `HUB75_SCAN_FRAME_SYNC_EN`.
- `frame_swap`  out  1  only with `HUB75_SCAN_FRAME_SYNC_EN`.

## Operation
- All outputs are registered.
- Reset values:
  - `phy_addr`=0, `phy_data`=0, `phy_clk`=0, `phy_le`=0, `phy_blank`=1.
  - `rd_row`/`rd_col`/`rd_plane`=0, `frame_swap`=0.
  - State IDLE, on-counter 0, scan position (row 0, plane 0).
- Main FSM states: IDLE, PREFETCH, SHIFT, WAIT, BLANK, LATCH.
- IDLE:
  - `phy_blank`=1.
  - If `ctrl_run`=1, go to PREFETCH at scan position (0,0).
- PREFETCH (1 cycle):
  - `rd_col`=0, with `rd_row`/`rd_plane` set to the scan position.
  - Go to SHIFT.
- SHIFT (2 cycles per column, column c=0..N_COLS-1):
  - Phase 0: `phy_data`<=`rd_data`, `phy_clk`<=0, `rd_col`<=c+1 (wraps to 0 after the last column).
  - Phase 1: `phy_clk`<=1.
  - After phase 1 of column N_COLS-1, `phy_clk` returns to 0 and the FSM goes to WAIT.
- WAIT: stay until the on-counter is 0, then go to BLANK.
- BLANK (1 cycle): `phy_blank`<=1, `phy_addr`<=`rd_row` (row just shifted).
- LATCH (1 cycle):
  - `phy_le`<=1.
  - Next cycle: `phy_le`<=0, `phy_blank`<=0, on-counter loaded with `BCM_LSB_LEN << plane_latched`.
- Position advance on leaving LATCH:
  - plane+1.
  - At plane N_PLANES-1: plane=0, row+1.
  - At row N_ROWS-1: row=0 (frame wrap).
- After LATCH:
  - `ctrl_run`=1: go to PREFETCH.
  - `ctrl_run`=0: go to IDLE. The on-time in progress completes, then blank goes high.
- On-counter:
  - Decrements each cycle while nonzero.
  - When it reaches 0, `phy_blank`<=1 regardless of FSM state, so an on-time shorter than a shift leaves LEDs blanked for the rest of the shift (exact BCM weights).
- Width: on-counter is `$clog2(BCM_LSB_LEN << (N_PLANES-1)) + 1` bits; no overflow permitted.

## Timing
- Shift phase: 1 + 2*N_COLS cycles from PREFETCH entry to WAIT.
- `phy_data` changes only in phase 0 (when `phy_clk` goes low), so it is stable across the `phy_clk` high period.
- `phy_addr` changes only while `phy_blank`=1, one cycle before `phy_le`.
- Plane p blank-low window is exactly `BCM_LSB_LEN << p` cycles.
- If `ctrl_run` falls mid-shift, the current shift and latch complete first.
- `rst` mid-operation returns to the reset values on the next edge; no partial latch is emitted.

## Configuration
- `HUB75_SCAN_FRAME_SYNC_EN` defined:
  - Before PREFETCH of (row 0, plane 0), the FSM waits in an extra SYNC state until `frame_ready`=1.
  - On leaving SYNC it pulses `frame_swap` for 1 cycle, coincident with the PREFETCH cycle.
  - `phy_blank` keeps following the on-counter while in SYNC.
- Not defined: no SYNC state, and `frame_ready`/`frame_swap` ports are absent. Frame wrap is free-running.

## Test plan
Parameters unless stated: N_COLS=4, N_ROWS=4, N_PLANES=2, BCM_LSB_LEN=8.
- Reset: hold `rst` 3 cycles -> `phy_blank`=1, all other outputs 0; no `phy_clk` edges while `ctrl_run`=0.
- Shift: `ctrl_run`=1, buffer returns `rd_data`=col index -> 4 `phy_clk` rising edges, `phy_data` 0,1,2,3 stable at each; `phy_le` pulses 1 cycle afterwards with `phy_addr`=0.
- BCM weights: measure blank-low windows -> plane 0 = 8 cycles, plane 1 = 16 cycles; row advances 0→1 after plane 1.
- Short on-time: BCM_LSB_LEN=1 -> `phy_blank` low exactly 1 cycle per plane-0 latch, high during the remaining shift.
- Wrap and stop: run 8 latches -> `phy_addr` sequence 0,0,1,1,2,2,3,3 then 0; drop `ctrl_run` -> IDLE after next latch, `phy_blank`=1 after on-time.
- Frame sync (macro on): `frame_ready`=0 -> stalls in SYNC with no `phy_clk`. Raise it -> one-cycle `frame_swap` and scan resumes. Also apply `rst` mid-SHIFT -> reset values next cycle.
